// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared types and default timing for the push-button conditioner.
//   - btn_state_e : per-channel debounce/press-tracking state (3-bit encoding)
//   - DEF_*       : default parameters derived from the 100 MHz board clock
//   - state_level : debounced level implied by a channel state
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

    localparam int unsigned CLK_HZ              = 100_000_000;
    localparam int unsigned DEF_NUM_BTN         = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES     = CLK_HZ;         // 1 s
    localparam int unsigned DEF_CNT_W           = 27;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_DOWN         = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_e;

    // The debounced level is 1 from the accepted press until the accepted
    // release, so RELEASE_WAIT still reports the button as down.
    function automatic logic state_level(input btn_state_e s);
        return (s == ST_DOWN) || (s == ST_HELD) || (s == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the button-side inputs and the conditioned event outputs.
//   btn_raw  : raw asynchronous button levels, 1 = pressed
//   mask     : 1 = suppress pulses for that channel (level still tracks)
//   level    : debounced button level
//   pressed  : one-cycle pulse on accepted press
//   released : one-cycle pulse on accepted release
//   held     : one-cycle pulse when a press has lasted HOLD_CYCLES
//   Modports: master drives btn_raw/mask, slave (the conditioner) drives
//   the conditioned outputs.
// ---------------------------------------------------------------------------
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN = DEF_NUM_BTN
) ();

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] mask;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pressed;
    logic [NUM_BTN-1:0] released;
    logic [NUM_BTN-1:0] held;

    modport master (
        output btn_raw,
        output mask,
        input  level,
        input  pressed,
        input  released,
        input  held
    );

    modport slave (
        input  btn_raw,
        input  mask,
        output level,
        output pressed,
        output released,
        output held
    );

endinterface

// File: rtl/button_conditioner_btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
//   One button: 2-FF synchroniser, debounce filter and press / release /
//   long-press detection. Outputs are the next-cycle values (_d); the top
//   level registers them so every conditioner output comes from a flop.
//   clk, rst     : system clock, synchronous active-low reset
//   btn_raw_i    : raw asynchronous button level
//   level_d_o    : debounced level to be registered
//   pressed_d_o  : accepted-press event to be registered
//   released_d_o : accepted-release event to be registered
//   held_d_o     : long-press event to be registered
// ---------------------------------------------------------------------------
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_d_o,
    output logic pressed_d_o,
    output logic released_d_o,
    output logic held_d_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             sync1_q;
    logic             raw_s_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_flag_q, held_flag_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the two
    // synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            raw_s_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            held_flag_q <= 1'b0;
        end else begin
            sync1_q     <= btn_raw_i;
            raw_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            held_flag_q <= held_flag_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        held_flag_d  = held_flag_q;
        pressed_d_o  = 1'b0;
        released_d_o = 1'b0;
        held_d_o     = 1'b0;

        // Each terminal compare leaves its state, so cnt never wraps.
        unique case (state_q)
            ST_IDLE: begin
                if (raw_s_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!raw_s_q) begin
                    state_d = ST_IDLE;             // bounce, no event
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = ST_DOWN;
                    cnt_d       = '0;
                    pressed_d_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (!raw_s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d     = ST_HELD;
                    held_d_o    = 1'b1;
                    held_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!raw_s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (raw_s_q) begin
                    // A release bounce goes back without re-firing held;
                    // before the long press it restarts hold timing.
                    state_d = held_flag_q ? ST_HELD : ST_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d      = ST_IDLE;
                    released_d_o = 1'b1;
                    held_flag_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                held_flag_d = 1'b0;
            end
        endcase

        level_d_o = state_level(state_d);
    end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns raw bouncy push-button levels into clean one-cycle events for the
//   stopwatch control logic. One btn_channel per button; this level adds the
//   output registers and the per-channel pulse mask.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : button_conditioner_if.slave (btn_raw, mask in; level, pressed,
//         released, held out)
// ---------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.slave bus
);

    logic [NUM_BTN-1:0] ch_level_d;
    logic [NUM_BTN-1:0] ch_pressed_d;
    logic [NUM_BTN-1:0] ch_released_d;
    logic [NUM_BTN-1:0] ch_held_d;

    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] pressed_q;
    logic [NUM_BTN-1:0] released_q;
    logic [NUM_BTN-1:0] held_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .btn_raw_i    (bus.btn_raw[g]),
            .level_d_o    (ch_level_d[g]),
            .pressed_d_o  (ch_pressed_d[g]),
            .released_d_o (ch_released_d[g]),
            .held_d_o     (ch_held_d[g])
        );
    end

    // Masking at the register input means a mask edge can only drop an
    // event, never create or stretch one: the event itself is one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q    <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            held_q     <= '0;
        end else begin
            level_q    <= ch_level_d;
            pressed_q  <= ch_pressed_d  & ~bus.mask;
            released_q <= ch_released_d & ~bus.mask;
            held_q     <= ch_held_d     & ~bus.mask;
        end
    end

    assign bus.level    = level_q;
    assign bus.pressed  = pressed_q;
    assign bus.released = released_q;
    assign bus.held     = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   HOLD_CYCLES=16. Expected events are scheduled by absolute cycle number
//   from hand-computed latencies; every cycle all four outputs are compared
//   against those schedules.
//   Cycle convention: tick() waits for a rising edge, bumps cyc, and samples
//   1 time unit later. Inputs changed after tick() at cycle t are first seen
//   at edge t+1, so a clean change shows up at cycle t+LAT
//   (1 + 2 sync + DEBOUNCE edges = 7).
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB   = 5;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int CW   = 5;
    localparam int LAT  = 7;
    localparam int MAXC = 1024;

    logic clk;
    logic rst;

    button_conditioner_if #(.NUM_BTN(NB)) bus ();

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected schedules, indexed by absolute cycle.
    logic [NB-1:0] ep   [MAXC];
    logic [NB-1:0] er   [MAXC];
    logic [NB-1:0] eh   [MAXC];
    logic [NB-1:0] lset [MAXC];
    logic [NB-1:0] lclr [MAXC];
    logic [NB-1:0] exp_level;

    int cyc;
    int n_vec;
    int n_miss;
    int t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        exp_level = (exp_level | lset[cyc]) & ~lclr[cyc];
        check("pressed",  32'(bus.pressed),  32'(ep[cyc]));
        check("released", 32'(bus.released), 32'(er[cyc]));
        check("held",     32'(bus.held),     32'(eh[cyc]));
        check("level",    32'(bus.level),    32'(exp_level));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_press(input int ch, input int c, input bit pulse);
        lset[c][ch] = 1'b1;
        if (pulse) ep[c][ch] = 1'b1;
    endtask

    task automatic exp_release(input int ch, input int c, input bit pulse);
        lclr[c][ch] = 1'b1;
        if (pulse) er[c][ch] = 1'b1;
    endtask

    task automatic exp_held(input int ch, input int c);
        eh[c][ch] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            ep[i]   = '0;
            er[i]   = '0;
            eh[i]   = '0;
            lset[i] = '0;
            lclr[i] = '0;
        end
        exp_level   = '0;
        cyc         = 0;
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b0;
        bus.btn_raw = '0;
        bus.mask    = '0;

        // Reset state: everything reads 0.
        run(3);
        rst = 1'b1;
        run(3);

        // Clean press and release on channel 0.
        t = cyc; bus.btn_raw[0] = 1'b1; exp_press(0, t + LAT, 1'b1);
        run(12);
        t = cyc; bus.btn_raw[0] = 1'b0; exp_release(0, t + LAT, 1'b1);
        run(10);

        // Bounce rejection on channel 1, then a real press.
        bus.btn_raw[1] = 1'b1; run(2);
        bus.btn_raw[1] = 1'b0; run(2);
        bus.btn_raw[1] = 1'b1; run(2);
        bus.btn_raw[1] = 1'b0; run(10);
        t = cyc; bus.btn_raw[1] = 1'b1; exp_press(1, t + LAT, 1'b1);
        run(10);
        t = cyc; bus.btn_raw[1] = 1'b0; exp_release(1, t + LAT, 1'b1);
        run(10);

        // Long press on channel 2 with a 2-cycle release bounce.
        t = cyc; bus.btn_raw[2] = 1'b1;
        exp_press(2, t + LAT, 1'b1);
        exp_held(2, t + LAT + HOLD);
        run(40);
        bus.btn_raw[2] = 1'b0; run(2);
        bus.btn_raw[2] = 1'b1; run(2);
        t = cyc; bus.btn_raw[2] = 1'b0; exp_release(2, t + LAT, 1'b1);
        run(12);

        // Masked press/release on channel 3: level only.
        t = cyc; bus.mask[3] = 1'b1; bus.btn_raw[3] = 1'b1;
        exp_press(3, t + LAT, 1'b0);
        run(10);
        t = cyc; bus.btn_raw[3] = 1'b0; exp_release(3, t + LAT, 1'b0);
        run(10);

        // Masked press, mask cleared mid-hold: no late pressed, held and
        // released appear normally.
        t = cyc; bus.btn_raw[3] = 1'b1;
        exp_press(3, t + LAT, 1'b0);
        exp_held(3, t + LAT + HOLD);
        run(10);
        bus.mask[3] = 1'b0;
        run(20);
        t = cyc; bus.btn_raw[3] = 1'b0; exp_release(3, t + LAT, 1'b1);
        run(12);

        // Simultaneous presses on channels 0 and 4, then reset mid-press.
        t = cyc; bus.btn_raw[0] = 1'b1; bus.btn_raw[4] = 1'b1;
        exp_press(0, t + LAT, 1'b1);
        exp_press(4, t + LAT, 1'b1);
        run(10);
        bus.btn_raw[4] = 1'b0; exp_release(4, t + 10 + LAT, 1'b1);
        run(10);
        // cyc == t+20, channel 0 in DOWN with the button still pressed.
        rst = 1'b0;
        lclr[t + 21] = '1;
        run(1);
        rst = 1'b1;
        // First non-reset edge t+22 samples the button: 2 sync + 4 debounce.
        exp_press(0, t + 28, 1'b1);
        run(14);
        bus.btn_raw[0] = 1'b0; exp_release(0, t + 35 + LAT, 1'b1);
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-side counterpart to the display path: it takes raw, asynchronous, bouncy push-button levels (start, stop, lap, clr, TimeSet) and delivers clean one-cycle event pulses to the stopwatch control logic. Each button is conditioned independently:
- 2-FF synchroniser
- debounce filter
- press/release/long-press detection
It sits between the board pins and stopwatch_top, replacing ad-hoc edge catching.

Parameters:
NUM_BTN, 5, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz)
HOLD_CYCLES, 100000000, cycles in the accepted-pressed state before a long-press pulse fires (1 s at 100 MHz)
CNT_W, 27, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES)-1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
btn_raw  in  NUM_BTN  asynchronous raw button levels, 1 = pressed
mask  in  NUM_BTN  1 = suppress pulses for that channel; state tracking continues
level  out  NUM_BTN  debounced button level
pressed  out  NUM_BTN  one-cycle pulse on accepted press
released  out  NUM_BTN  one-cycle pulse on accepted release
held  out  NUM_BTN  one-cycle pulse when a press has lasted HOLD_CYCLES

Behaviour:
- Reset:
  - rst sampled low at a clk edge clears synchroniser flops, counters, per-channel state (IDLE) and held_flag.
  - All outputs read 0 on the following cycle.
  - Reset mid-press: the channel returns to IDLE; a still-pressed button must be re-debounced and then produces a fresh pressed pulse.
- Synchroniser: two flops per channel; raw_s is btn_raw delayed 2 edges.
- Per-channel FSM, counter cnt:
  - IDLE (level=0): raw_s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: raw_s=0 -> IDLE (bounce rejected, no pulse). cnt==DEBOUNCE_CYCLES-1 with raw_s=1 -> DOWN, cnt=0, pressed pulse, level=1. Otherwise cnt+1.
  - DOWN: raw_s=0 -> RELEASE_WAIT, cnt=0. cnt==HOLD_CYCLES-1 -> HELD, held pulse, held_flag=1. Otherwise cnt+1.
  - HELD: raw_s=0 -> RELEASE_WAIT, cnt=0.
  - RELEASE_WAIT (level stays 1): raw_s=1 -> HELD if held_flag, else DOWN with cnt=0 (hold timing restarts). cnt==DEBOUNCE_CYCLES-1 with raw_s=0 -> IDLE, released pulse, level=0, held_flag=0. Otherwise cnt+1.
- Latency: raw press stable from before edge k gives pressed=1 in the cycle after edge k+2+DEBOUNCE_CYCLES; same for release.
- Pulses:
  - All outputs are registered.
  - Each pulse is exactly 1 cycle wide, never repeated while the level is held.
  - pressed, released and held for a channel are mutually exclusive in any cycle.
- Mask:
  - The pulse output is ANDed with ~mask at the register input; level is unaffected.
  - Toggling mask never creates or stretches a pulse.
- Counters saturate by construction: the terminal compare causes a state change, so there is no wrap.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Parameter legality: DEBOUNCE_CYCLES >= 1, HOLD_CYCLES >= 1. The bench uses DEBOUNCE_CYCLES=4, HOLD_CYCLES=16.

Decomposition:
- Shared package:
  - state enum (IDLE, PRESS_WAIT, DOWN, HELD, RELEASE_WAIT), 3-bit encoding
  - default timing constants derived from the 100 MHz board clock
- One sub-module, btn_channel, is natural: synchroniser + FSM + counter for one button. It is instantiated NUM_BTN times in a generate loop, with mask gating at the top level.

Test Plan:
- Clean press (DEBOUNCE=4): btn_raw[0] 0->1 and held -> pressed[0]=1 for exactly 1 cycle, 7 edges after the change (2 sync + 4 debounce + 1 register); level[0]=1 thereafter, no other pulses.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 with 2-cycle periods, then stays 0 -> no pulses, level[1] stays 0; then 1 for 10 cycles -> single pressed[1].
- Long press (HOLD=16): hold btn_raw[2] for 40 cycles -> pressed once, held once 16 cycles after pressed, then on release one released pulse; a release bounce of 2 cycles produces no extra pulse and does not refire held.
- Mask: mask[3]=1, press/release btn_raw[3] -> level[3] follows with correct latency, pressed/released stay 0; clear mask mid-hold -> no retroactive pulse.
- Simultaneous: btn_raw[0] and btn_raw[4] rise on the same edge -> pressed[0] and pressed[4] pulse in the same cycle.
- Reset mid-operation: rst=0 for 1 cycle while channel 0 is in DOWN with the button still pressed -> all outputs 0 next cycle; after rst=1, pressed[0] fires again after the full debounce latency.
